// File: rtl/sa_main_mem.sv
`default_nettype none
// ============================================================================
// Module   : sa_main_mem
// Purpose  : Main-memory model/controller sitting behind the set-associative
//            cache controller. Serves one word read (refill) or write
//            (write-back) at a time, holds it for LATENCY cycles, then
//            signals completion with a single-cycle resp_ready pulse.
//            Saturating read/write completion counters are kept alongside.
// Ports    : clk        - clock, rising edge
//            rst        - synchronous reset, active-low
//            req_valid  - request strobe (pulse or held)
//            req_rw     - 1 = write, 0 = read
//            req_addr   - request address (word index = req_addr[MEM_AW+1:2])
//            req_data   - write data
//            resp_ready - one-cycle completion pulse
//            resp_data  - registered read data, held until the next read
//            busy       - request accepted and not yet completed
//            rd_count   - completed reads, saturating
//            wr_count   - completed writes, saturating
// Revision : 1.0 - initial release
// ============================================================================
module sa_main_mem #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 20,
  parameter int MEM_AW  = 12,
  parameter int LATENCY = 4,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              busy,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  generate
    if ((LATENCY < 1) || (LATENCY > 255)) begin : g_bad_latency
      $error("sa_main_mem: LATENCY must be in the range 1..255");
    end
  endgenerate

  logic [1:0]        state_q,     state_d;
  logic [7:0]        cnt_q,       cnt_d;
  logic              rw_q,        rw_d;
  logic [MEM_AW-1:0] idx_q,       idx_d;
  logic [DATA_W-1:0] wdata_q,     wdata_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic [CNT_W-1:0]  rd_count_q,  rd_count_d;
  logic [CNT_W-1:0]  wr_count_q,  wr_count_d;
  logic              mem_we;

  // Word array; deliberately left uninitialised by reset.
  logic [DATA_W-1:0] mem [2**MEM_AW];

  // Address bits outside the word index are ignored, so addresses alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[ADDR_W-1:MEM_AW+2], req_addr[1:0]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rw_d        = rw_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    resp_data_d = resp_data_q;
    rd_count_d  = rd_count_q;
    wr_count_d  = wr_count_q;
    mem_we      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          rw_d    = req_rw;
          idx_d   = req_addr[MEM_AW+1:2];
          wdata_d = req_data;
          cnt_d   = CNT_INIT;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          // Access point: writes commit here, reads capture the word.
          if (rw_q) begin
            mem_we = 1'b1;
          end else begin
            resp_data_d = mem[idx_q];
          end
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rw_q) begin
          if (wr_count_q != {CNT_W{1'b1}}) wr_count_d = wr_count_q + CNT_W'(1);
        end else begin
          if (rd_count_q != {CNT_W{1'b1}}) rd_count_d = rd_count_q + CNT_W'(1);
        end
        // Any request seen during this cycle is ignored.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      rw_q        <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      resp_data_q <= '0;
      rd_count_q  <= '0;
      wr_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rw_q        <= rw_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      resp_data_q <= resp_data_d;
      rd_count_q  <= rd_count_d;
      wr_count_q  <= wr_count_d;
    end
  end

  // A write caught by reset before its access point never reaches the array.
  always_ff @(posedge clk) begin
    if (rst && mem_we) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign resp_ready = (state_q == S_RESP);
  assign busy       = (state_q == S_BUSY);
  assign resp_data  = resp_data_q;
  assign rd_count   = rd_count_q;
  assign wr_count   = wr_count_q;

endmodule
`default_nettype wire

// File: tb/tb_sa_main_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_sa_main_mem
// Purpose  : Self-checking bench for sa_main_mem. Requests are issued from a
//            stimulus process; each one pushes an expected response (kind,
//            word index, data, completion cycle) into a queue. A monitor
//            process compares every cycle's handshake and data against it,
//            using a word-indexed associative array as the memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sa_main_mem;

  localparam int L  = 4;
  localparam int AW = 20;
  localparam int MA = 12;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_rw;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_data;
  logic          resp_ready;
  logic [31:0]   resp_data;
  logic          busy;
  logic [CW-1:0] rd_count;
  logic [CW-1:0] wr_count;

  sa_main_mem #(.DATA_W(32), .ADDR_W(AW), .MEM_AW(MA), .LATENCY(L), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_rw(req_rw),
    .req_addr(req_addr), .req_data(req_data), .resp_ready(resp_ready),
    .resp_data(resp_data), .busy(busy), .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rw;
    int          idx;
    logic [31:0] wd;
    int          rcyc;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mdl [int];
  logic [31:0] last_rd;
  bit          last_known;
  int          rd_m, wr_m;
  int          errors = 0, checks = 0;
  int          cyc = 0;
  int          next_free = 0;
  int          cmax = (1 << CW) - 1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int widx(input logic [AW-1:0] a);
    return (int'(a) / 4) % (1 << MA);
  endfunction

  // Monitor: checks handshake every cycle, data on each completion.
  initial begin
    exp_t e;
    bit   due, bexp;
    forever begin
      @(negedge clk);
      #1;
      if (rst === 1'b1) begin
        due  = (q.size() > 0) && (cyc == q[0].rcyc);
        bexp = (q.size() > 0) && (cyc >= q[0].rcyc - L) && (cyc < q[0].rcyc);
        chk("resp_ready", resp_ready, due);
        chk("busy", busy, bexp);
        if (due) begin
          e = q.pop_front();
          chk("rd_count", rd_count, rd_m);
          chk("wr_count", wr_count, wr_m);
          if (e.rw) begin
            mdl[e.idx] = e.wd;
            if (last_known) chk("resp_data_hold", resp_data, last_rd);
            if (wr_m < cmax) wr_m++;
          end else begin
            if (mdl.exists(e.idx)) begin
              chk("rd_data", resp_data, mdl[e.idx]);
              last_rd    = mdl[e.idx];
              last_known = 1'b1;
            end else begin
              last_known = 1'b0;
            end
            if (rd_m < cmax) rd_m++;
          end
        end
      end
    end
  end

  // Issue one request; returns at the negedge after the accept edge.
  task automatic issue(input bit rw, input logic [AW-1:0] a, input logic [31:0] d, input bit hold);
    exp_t e;
    while (cyc < next_free) @(negedge clk);
    req_valid = 1'b1;
    req_rw    = rw;
    req_addr  = a;
    req_data  = d;
    e.rw   = rw;
    e.idx  = widx(a);
    e.wd   = d;
    e.rcyc = cyc + 1 + L;
    q.push_back(e);
    next_free = cyc + L + 2;
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
    // Bus changes after acceptance must not affect the access.
    req_rw   = 1'($urandom);
    req_addr = AW'($urandom);
    req_data = $urandom;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && cyc < next_free; k++) @(negedge clk);
    chk("drain", q.size(), 0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    q.delete();
    repeat (n) @(negedge clk);
    req_valid  = 1'b0;
    rst        = 1'b1;
    rd_m       = 0;
    wr_m       = 0;
    last_rd    = '0;
    last_known = 1'b1;
    next_free  = cyc;
  endtask

  initial begin
    bit          prev_hold;
    bit          h;
    logic [AW-1:0] a;
    rst = 1'b0; req_valid = 1'b1; req_rw = 1'b1; req_addr = 20'h00040; req_data = 32'hFFFF_FFFF;

    // Reset held for three cycles with a request pending.
    @(negedge clk);
    do_reset(3);
    #1;
    chk("reset_ready", resp_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_rd_count", rd_count, 0);
    chk("reset_wr_count", wr_count, 0);
    chk("reset_resp_data", resp_data, 0);

    // Write then read the same word.
    issue(1'b1, 20'h00010, 32'hDEADBEEF, 1'b0);
    issue(1'b0, 20'h00010, 32'h0, 1'b0);
    drain();
    chk("wr_rd_data", resp_data, 32'hDEADBEEF);
    chk("wr_rd_rdcnt", rd_count, 1);
    chk("wr_rd_wrcnt", wr_count, 1);

    // Held request: back-to-back accesses, RESP cycle never accepts.
    for (int i = 0; i < 6; i++)
      issue(1'(i % 2), 20'h00100 + AW'(4 * (i / 2)), $urandom, i < 5);
    drain();

    // Reset during BUSY drops a write.
    issue(1'b1, 20'h00020, 32'h11111111, 1'b0);
    drain();
    issue(1'b1, 20'h00020, 32'h12345678, 1'b0);
    @(negedge clk);
    do_reset(2);
    issue(1'b0, 20'h00020, 32'h0, 1'b0);
    drain();
    chk("drop_data", resp_data, 32'h11111111);
    chk("drop_wrcnt", wr_count, 0);

    // Aliasing through ignored upper address bits.
    issue(1'b1, 20'h04008, 32'h000000A5, 1'b0);
    issue(1'b0, 20'h00008, 32'h0, 1'b0);
    drain();
    chk("alias_data", resp_data, 32'h000000A5);

    // Counter saturation.
    for (int i = 0; i < 5; i++) issue(1'b0, 20'h00008, 32'h0, 1'b0);
    drain();
    chk("rd_saturate", rd_count, 3);

    // Randomised traffic over a small aliased pool of words.
    prev_hold = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!prev_hold) repeat ($urandom_range(0, 2)) @(negedge clk);
      a = AW'(($urandom_range(0, 63) << 14) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
      h = (i < 59) ? 1'($urandom_range(0, 1)) : 1'b0;
      issue(1'($urandom_range(0, 1)), a, $urandom, h);
      prev_hold = h;
    end
    drain();
    chk("final_rd_count", rd_count, rd_m);
    chk("final_wr_count", wr_count, wr_m);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
